// File: rtl/shift_seq_if.sv
// Request/response bundle for the iterative shifter: operands and start
// go in, busy/done/err/result come back.
interface shift_seq_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] Ra;
  logic [4:0]  shift_amt;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] result;

  modport master (output start, op, Ra, shift_amt,
                  input  busy, done, err, result);
  modport slave  (input  start, op, Ra, shift_amt,
                  output busy, done, err, result);
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle shifter/rotator: moves STEP bit positions per RUN cycle and
// publishes only the final value, with a one-cycle done (and err) pulse.
module shift_seq #(
  parameter int STEP = 1
) (
  input  logic        clock,
  input  logic        clear,
  shift_seq_if.slave  bus
);

  localparam logic [4:0] STEP_C = 5'(STEP);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  k;
  logic [2:0]  op_q, op_d;
  logic        err_q, err_d;

  function automatic logic op_legal(input logic [2:0] o);
    return (o <= 3'd4);
  endfunction

  function automatic logic [31:0] shift_by(input logic [2:0] o,
                                           input logic [31:0] v,
                                           input logic [4:0] amt);
    logic [63:0] dbl;
    logic [31:0] r;
    dbl = {v, v};
    case (o)
      3'd0:    r = v >> amt;
      3'd1:    r = 32'($signed(v) >>> amt);
      3'd2:    r = v << amt;
      3'd3:    begin dbl = dbl >> amt; r = dbl[31:0];  end
      3'd4:    begin dbl = dbl << amt; r = dbl[63:32]; end
      default: r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q  <= IDLE;
      work_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    err_d    = err_q;
    k        = (cnt_q < STEP_C) ? cnt_q : STEP_C;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d = bus.Ra;
          op_d   = bus.op;
          cnt_d  = bus.shift_amt;
          err_d  = !op_legal(bus.op);
          // Zero amount and illegal ops both finish with Ra untouched.
          if (bus.shift_amt == 5'd0 || !op_legal(bus.op)) begin
            state_d  = DONE;
            result_d = bus.Ra;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        work_d = shift_by(op_q, work_q, k);
        cnt_d  = cnt_q - k;
        if (cnt_q == k) begin
          state_d  = DONE;
          result_d = work_d;
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.err    = err_q && (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: three instances (STEP 1, 4, 8) driven from a
// vector table, plus hand-written start-during-RUN and mid-RUN clear sequences.
module tb_shift_seq;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  shift_seq_if if0 ();
  shift_seq_if if1 ();
  shift_seq_if if2 ();

  shift_seq #(.STEP(1)) u0 (.clock(clock), .clear(clear), .bus(if0));
  shift_seq #(.STEP(4)) u1 (.clock(clock), .clear(clear), .bus(if1));
  shift_seq #(.STEP(8)) u2 (.clock(clock), .clear(clear), .bus(if2));

  logic        start_r [3];
  logic [2:0]  op_r    [3];
  logic [31:0] ra_r    [3];
  logic [4:0]  amt_r   [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic        err_w   [3];
  logic [31:0] res_w   [3];

  assign if0.start = start_r[0]; assign if0.op = op_r[0];
  assign if0.Ra = ra_r[0];       assign if0.shift_amt = amt_r[0];
  assign if1.start = start_r[1]; assign if1.op = op_r[1];
  assign if1.Ra = ra_r[1];       assign if1.shift_amt = amt_r[1];
  assign if2.start = start_r[2]; assign if2.op = op_r[2];
  assign if2.Ra = ra_r[2];       assign if2.shift_amt = amt_r[2];

  assign busy_w[0] = if0.busy; assign done_w[0] = if0.done;
  assign err_w[0]  = if0.err;  assign res_w[0]  = if0.result;
  assign busy_w[1] = if1.busy; assign done_w[1] = if1.done;
  assign err_w[1]  = if1.err;  assign res_w[1]  = if1.result;
  assign busy_w[2] = if2.busy; assign done_w[2] = if2.done;
  assign err_w[2]  = if2.err;  assign res_w[2]  = if2.result;

  typedef struct {
    int          d;
    logic [2:0]  op;
    logic [31:0] ra;
    logic [4:0]  n;
    logic [31:0] res;
    logic        err;
    int          lat;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one request on instance d and follow it to completion.
  task automatic run_op(input int d, input logic [2:0] op, input logic [31:0] ra,
                        input logic [4:0] n, input logic [31:0] res,
                        input logic err, input int lat, input int idx);
    int cyc;
    int busy_cnt;
    @(negedge clock);
    start_r[d] = 1'b1; op_r[d] = op; ra_r[d] = ra; amt_r[d] = n;
    @(posedge clock); #1;
    // Scramble operands after the accept edge; they must have no effect.
    start_r[d] = 1'b0; op_r[d] = 3'b111; ra_r[d] = ~ra; amt_r[d] = ~n;
    cyc = 0;
    busy_cnt = 0;
    while (!done_w[d] && cyc < 40) begin
      chk($sformatf("v%0d err_without_done", idx), 32'(err_w[d]), 32'd0);
      if (busy_w[d]) busy_cnt++;
      @(posedge clock); #1;
      cyc++;
    end
    if (busy_w[d]) busy_cnt++;
    chk($sformatf("v%0d done_seen", idx), 32'(done_w[d]), 32'd1);
    chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(lat));
    chk($sformatf("v%0d result", idx), res_w[d], res);
    chk($sformatf("v%0d err", idx), 32'(err_w[d]), 32'(err));
    chk($sformatf("v%0d busy_cycles", idx), 32'(busy_cnt), 32'(lat + 1));
    @(posedge clock); #1;
    chk($sformatf("v%0d done_one_cycle", idx), 32'(done_w[d]), 32'd0);
    chk($sformatf("v%0d idle_after", idx), 32'(busy_w[d]), 32'd0);
    chk($sformatf("v%0d err_after", idx), 32'(err_w[d]), 32'd0);
    chk($sformatf("v%0d result_held", idx), res_w[d], res);
  endtask

  initial begin
    int pulses;
    logic [31:0] seen;

    tbl[0]  = '{0, 3'b011, 32'hF0F0F0F0, 5'd4,  32'h0F0F0F0F, 1'b0, 4};
    tbl[1]  = '{0, 3'b001, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 31};
    tbl[2]  = '{0, 3'b000, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 31};
    tbl[3]  = '{0, 3'b010, 32'h00000001, 5'd20, 32'h00100000, 1'b0, 20};
    tbl[4]  = '{0, 3'b100, 32'h12345678, 5'd16, 32'h56781234, 1'b0, 16};
    tbl[5]  = '{0, 3'b111, 32'hDEADBEEF, 5'd5,  32'hDEADBEEF, 1'b1, 0};
    tbl[6]  = '{0, 3'b001, 32'h7FFF0000, 5'd8,  32'h007FFF00, 1'b0, 8};
    tbl[7]  = '{0, 3'b100, 32'h80000001, 5'd1,  32'h00000003, 1'b0, 1};
    tbl[8]  = '{0, 3'b000, 32'h12345678, 5'd0,  32'h12345678, 1'b0, 0};
    tbl[9]  = '{0, 3'b101, 32'hCAFEF00D, 5'd0,  32'hCAFEF00D, 1'b1, 0};
    tbl[10] = '{1, 3'b100, 32'h12345678, 5'd16, 32'h56781234, 1'b0, 4};
    tbl[11] = '{1, 3'b000, 32'hFFFFFFFF, 5'd7,  32'h01FFFFFF, 1'b0, 2};
    tbl[12] = '{1, 3'b001, 32'h80000000, 5'd5,  32'hFC000000, 1'b0, 2};
    tbl[13] = '{2, 3'b011, 32'hAAAAAAAA, 5'd31, 32'h55555555, 1'b0, 4};
    tbl[14] = '{2, 3'b011, 32'hAAAAAAAA, 5'd0,  32'hAAAAAAAA, 1'b0, 0};
    tbl[15] = '{2, 3'b010, 32'h0000FFFF, 5'd9,  32'h01FFFE00, 1'b0, 2};

    for (int i = 0; i < 3; i++) begin
      start_r[i] = 1'b0; op_r[i] = '0; ra_r[i] = '0; amt_r[i] = '0;
    end

    #3;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_busy%0d", i), 32'(busy_w[i]), 32'd0);
      chk($sformatf("reset_done%0d", i), 32'(done_w[i]), 32'd0);
      chk($sformatf("reset_err%0d", i), 32'(err_w[i]), 32'd0);
      chk($sformatf("reset_result%0d", i), res_w[i], 32'd0);
    end
    repeat (2) @(negedge clock);
    clear = 1'b1;

    for (int i = 0; i < NV; i++)
      run_op(tbl[i].d, tbl[i].op, tbl[i].ra, tbl[i].n, tbl[i].res,
             tbl[i].err, tbl[i].lat, i);

    // A second start during RUN must be dropped, not queued.
    @(negedge clock);
    start_r[0] = 1'b1; op_r[0] = 3'b010; ra_r[0] = 32'h00000001; amt_r[0] = 5'd8;
    @(posedge clock); #1;
    start_r[0] = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    start_r[0] = 1'b1; op_r[0] = 3'b011; ra_r[0] = 32'hFFFFFFFF; amt_r[0] = 5'd3;
    @(posedge clock); #1;
    start_r[0] = 1'b0;
    pulses = 0;
    seen = '0;
    for (int c = 0; c < 25; c++) begin
      if (done_w[0]) begin
        pulses++;
        seen = res_w[0];
      end
      @(posedge clock); #1;
    end
    chk("run_start_pulses", 32'(pulses), 32'd1);
    chk("run_start_result", seen, 32'h00000100);
    chk("run_start_idle", 32'(busy_w[0]), 32'd0);

    // Clear in the middle of a long RUN aborts it without a done pulse.
    @(negedge clock);
    start_r[0] = 1'b1; op_r[0] = 3'b010; ra_r[0] = 32'h00000001; amt_r[0] = 5'd20;
    @(posedge clock); #1;
    start_r[0] = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    chk("pre_clear_busy", 32'(busy_w[0]), 32'd1);
    clear = 1'b0;
    #1;
    chk("clear_busy", 32'(busy_w[0]), 32'd0);
    chk("clear_done", 32'(done_w[0]), 32'd0);
    chk("clear_result", res_w[0], 32'd0);
    repeat (2) @(negedge clock);
    clear = 1'b1;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clock); #1;
      if (done_w[0]) pulses++;
    end
    chk("clear_no_done", 32'(pulses), 32'd0);
    chk("clear_result_hold", res_w[0], 32'd0);

    run_op(0, 3'b010, 32'h00000001, 5'd20, 32'h00100000, 1'b0, 20, 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter: STEP, default 1, bits shifted per RUN cycle; legal values 1, 2, 4, 8; other values are unsupported.
REQ-002 Port: clock  in  1  system clock; all state updates on its rising edge.
REQ-003 Port: clear  in  1  reset, asynchronous and active-low.
REQ-004 Port: start  in  1  request strobe, sampled on each rising clock edge.
REQ-005 Port: op  in  3  operation code: 000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; 101-111 illegal.
REQ-006 Port: Ra  in  32  operand, sampled only on an accept edge.
REQ-007 Port: shift_amt  in  5  shift or rotate amount n (0-31), sampled only on an accept edge.
REQ-008 Port: busy  out  1  high whenever state is not IDLE.
REQ-009 Port: done  out  1  one-cycle completion pulse.
REQ-010 Port: err  out  1  one-cycle illegal-op flag, coincident with done.
REQ-011 Port: result  out  32  registered result, held stable between completions.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE; busy = (state != IDLE).
REQ-013 Accept edge: a rising edge with start=1 while in IDLE. At this edge Ra, op and shift_amt SHALL be latched into the work register, the op register and the count register.
REQ-014 start SHALL be ignored in RUN and DONE; no request is queued.
REQ-015 Accept with n=0 or an illegal op SHALL go IDLE->DONE; accept with n>0 and a legal op SHALL go IDLE->RUN.
REQ-016 Each RUN edge SHALL apply k = min(STEP, count) bit positions of the latched op to the work register and set count = count-k.
REQ-017 RUN SHALL go to DONE on the edge where count-k = 0; otherwise it SHALL stay in RUN.
REQ-018 DONE SHALL last exactly one cycle, then go to IDLE unconditionally.
REQ-019 Latency: done SHALL be high in the cycle following edge E0+ceil(n/STEP), where E0 is the accept edge; for n=0 this is the cycle following E0.
REQ-020 Fill rules per op:
  - SHR: zero-fill from the MSB side.
  - SHRA: replicate bit 31.
  - SHL: zero-fill from the LSB side.
  - ROR and ROL: circular over 32 bits.
  - The result SHALL equal the single-shot operation by n bits.
REQ-021 result SHALL load the final work value on the edge entering DONE and hold it until the next entry into DONE; intermediate values SHALL NOT appear on result.
REQ-022 Illegal op: result SHALL be loaded with the latched Ra, and err SHALL be high together with done.
REQ-023 err SHALL be 0 in every cycle in which done is 0.
REQ-024 Inputs SHALL be ignored outside accept edges; changes to Ra, op or shift_amt during RUN SHALL NOT affect the operation in progress.
REQ-025 Back-to-back operation: the earliest next accept is the edge that leaves DONE for IDLE plus one cycle, so the issue interval is ceil(n/STEP)+2 cycles.

Reset
REQ-026 clear=0 SHALL, asynchronously and without a clock edge, force: state=IDLE, busy=0, done=0, err=0, result=32'h0, and the work and count registers to 0.
REQ-027 clear asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL be produced for the aborted request.
REQ-028 After clear is deasserted, the first rising edge with start=1 SHALL be a valid accept edge.

Verification
REQ-029 STEP=1; ROR, Ra=F0F0F0F0, n=4 -> done in the cycle after E0+4, result=0F0F0F0F, err=0, busy high for 5 cycles.
REQ-030 STEP=4; ROL, Ra=12345678, n=16 -> done in the cycle after E0+4, result=56781234.
REQ-031 STEP=1; SHRA, Ra=80000000, n=31 -> result=FFFFFFFF after 31 RUN cycles; repeated with SHR -> result=00000001.
REQ-032 STEP=8; ROR, Ra=AAAAAAAA, n=31 -> done in the cycle after E0+4, result=55555555. Also ROR with n=0 -> done in the cycle after E0, result=AAAAAAAA.
REQ-033 Illegal op 111, Ra=DEADBEEF -> done=1 and err=1 in the cycle after E0, result=DEADBEEF. Additionally, a start pulse during RUN (new Ra, op and n) -> ignored; the original result is unchanged and exactly one done pulse occurs.
REQ-034 clear=0 asserted mid-RUN (STEP=1, SHL, n=20, at cycle 10) -> busy, done and result go to 0 immediately, with no done pulse. After release, SHL with Ra=00000001 and n=20 -> result=00100000.
